// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises to the incoming stream, then
// counts bit errors against a free-running local reference and re-hunts on excessive errors.
module prbs31_checker #(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned LOSS_WIN    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 din,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state_o
);

  localparam logic [1:0] StSeed   = 2'b00;
  localparam logic [1:0] StHunt   = 2'b01;
  localparam logic [1:0] StLocked = 2'b10;

  localparam int unsigned WinW  = $clog2(LOSS_WIN);
  localparam int unsigned WerrW = $clog2(LOSS_THRESH + 1);

  localparam logic [7:0]           SeedLast = 8'd30;
  localparam logic [8:0]           LockCnt  = 9'(LOCK_COUNT);
  localparam logic [WinW-1:0]      WinLast  = WinW'(LOSS_WIN - 1);
  localparam logic [WerrW-1:0]     Thresh   = WerrW'(LOSS_THRESH);
  localparam logic [ERR_CNT_W-1:0] CntMax   = '1;

  logic [30:0]          hist_q, hist_d;
  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [WinW-1:0]      wbits_q, wbits_d;
  logic [WerrW-1:0]     werr_q, werr_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

  logic                 pred;
  logic                 mismatch;
  logic [WerrW-1:0]     werr_inc;
  logic [8:0]           match_inc;

  assign pred     = hist_q[30] ^ hist_q[27];
  assign mismatch = din ^ pred;

  always_comb begin
    hist_d    = hist_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    wbits_d   = wbits_q;
    werr_d    = werr_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    // werr_q always stays below Thresh, so the increment cannot overflow WerrW.
    werr_inc  = werr_q + WerrW'(mismatch);
    match_inc = {1'b0, cnt_q} + 9'd1;
    ecnt_d    = clr_cnt ? '0 : ecnt_q;

    if (en) begin
      case (state_q)
        StSeed: begin
          hist_d = {hist_q[29:0], din};
          if (cnt_q == SeedLast) begin
            state_d = StHunt;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        StHunt: begin
          hist_d = {hist_q[29:0], din};
          // An all-zero history predicts 0 forever; never count it, so stuck-at-0 cannot lock.
          if (!mismatch && (hist_q != '0)) begin
            if (match_inc == LockCnt) begin
              state_d  = StLocked;
              cnt_d    = '0;
              wbits_d  = '0;
              werr_d   = '0;
              locked_d = 1'b1;
            end else begin
              cnt_d = match_inc[7:0];
            end
          end else begin
            cnt_d = '0;
          end
        end

        StLocked: begin
          // Reference runs on its own prediction so a line error is never fed back.
          hist_d = {hist_q[29:0], pred};
          err_d  = mismatch;
          if (mismatch && (ecnt_d != CntMax)) begin
            ecnt_d = ecnt_d + ERR_CNT_W'(1);
          end
          if (werr_inc == Thresh) begin
            state_d  = StSeed;
            locked_d = 1'b0;
            hist_d   = '0;
            cnt_d    = '0;
            wbits_d  = '0;
            werr_d   = '0;
          end else if (wbits_q == WinLast) begin
            wbits_d = '0;
            werr_d  = '0;
          end else begin
            wbits_d = wbits_q + WinW'(1);
            werr_d  = werr_inc;
          end
        end

        default: begin
          state_d  = StSeed;
          locked_d = 1'b0;
          hist_d   = '0;
          cnt_d    = '0;
          wbits_d  = '0;
          werr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q   <= '0;
      state_q  <= StSeed;
      cnt_q    <= '0;
      wbits_q  <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      hist_q   <= hist_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wbits_q  <= wbits_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = ecnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based behavioural model of the checker.
module tb_prbs31_checker;

  localparam int unsigned LOCK_COUNT  = 32;
  localparam int unsigned LOSS_WIN    = 64;
  localparam int unsigned LOSS_THRESH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err, locked4, err4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  state_o, state4;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .state_o   (state_o)
  );

  prbs31_checker #(.ERR_CNT_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .err       (err4),
    .err_count (err_count4),
    .state_o   (state4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: oldest received/predicted bit at index 0 of the queue.
  bit m_hist[$];
  int m_state, m_seen, m_match, m_wbits, m_werr, m_cnt16, m_cnt4;
  bit m_locked, m_err;

  // Transmit-side PRBS31 generator, oldest bit at index 0.
  bit g[$];
  int lk_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear_hist();
    m_hist = {};
    for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_reset();
    model_clear_hist();
    m_state = 0; m_seen = 0; m_match = 0; m_wbits = 0; m_werr = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_locked = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(input bit e, input bit d, input bit c);
    bit p, nz;
    m_err = 1'b0;
    if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    if (e) begin
      p = m_hist[0] ^ m_hist[3];
      if (m_state == 0) begin
        model_push(d);
        m_seen++;
        if (m_seen == 31) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        nz = 1'b0;
        foreach (m_hist[i]) nz |= m_hist[i];
        if (d == p && nz) m_match++; else m_match = 0;
        model_push(d);
        if (m_match == LOCK_COUNT) begin
          m_state = 2; m_locked = 1'b1; m_wbits = 0; m_werr = 0;
        end
      end else begin
        model_push(p);
        m_wbits++;
        if (d != p) begin
          m_err = 1'b1;
          m_werr++;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_werr == LOSS_THRESH) begin
          m_state = 0; m_locked = 1'b0; m_seen = 0;
          model_clear_hist();
        end else if (m_wbits == LOSS_WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end
    end
  endfunction

  function automatic void gen_seed();
    g = {};
    for (int i = 0; i < 31; i++) g.push_back(1'($urandom_range(0, 1)));
    g[0] = 1'b1;
  endfunction

  function automatic bit gen_peek();
    return g[0] ^ g[3];
  endfunction

  function automatic bit gen_bit();
    bit b;
    b = g[0] ^ g[3];
    g.push_back(b);
    void'(g.pop_front());
    return b;
  endfunction

  task automatic compare_all();
    check("locked", locked, m_locked);
    check("err", err, m_err);
    check("state", state_o, m_state);
    check("err_count", err_count, m_cnt16);
    check("err_count_w4", err_count4, m_cnt4);
  endtask

  task automatic step(input bit e, input bit d, input bit c);
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    model_step(e, d, c);
    if (e) lk_bits++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_count_w4", err_count4, 0);
    check("rst_state", state_o, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input int limit, output int n);
    n = 0;
    while (!locked && n < limit) begin
      step(1'b1, gen_bit(), 1'b0);
      n++;
    end
    lk_bits = 0;
  endtask

  initial begin
    int n, pulses;
    bit ever, e, d, c;
    lk_bits = 0;
    model_reset();

    // Clean stream, lock latency, long clean run.
    do_reset();
    gen_seed();
    wait_lock(200, n);
    check("lock_latency", n, 63);
    for (int i = 0; i < 10000; i++) step(1'b1, gen_bit(), 1'b0);
    check("clean_err_count", err_count, 0);
    check("clean_locked", locked, 1);

    // Single inverted bit.
    pulses = 0;
    step(1'b1, gen_bit() ^ 1'b1, 1'b0);
    pulses += int'(err);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      pulses += int'(err);
    end
    check("single_err_pulses", pulses, 1);
    check("single_err_count", err_count, 1);
    check("single_err_locked", locked, 1);

    // Clear on the same edge as an error.
    step(1'b1, gen_bit() ^ 1'b1, 1'b1);
    check("clr_same_edge", err_count, 1);

    // Eight errors inside one window force loss of lock.
    step(1'b1, gen_bit(), 1'b1);
    while (lk_bits % LOSS_WIN != 0) step(1'b1, gen_bit(), 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, gen_bit() ^ 1'b1, 1'b0);
      if (i == 7) begin
        check("loss_locked", locked, 0);
        check("loss_state", state_o, 0);
      end else begin
        for (int k = 0; k < 3; k++) step(1'b1, gen_bit(), 1'b0);
      end
    end
    wait_lock(200, n);
    check("relock_latency", n, 63);
    check("relock_err_count", err_count, 8);

    // Seven errors per window for three windows keep lock.
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 64; b++)
        step(1'b1, gen_bit() ^ ((b % 9 == 0) && (b < 60)), 1'b0);
    check("seven_per_win_locked", locked, 1);
    check("seven_per_win_count", err_count, 29);

    // Stuck-at-0 and stuck-at-1 lines never lock.
    for (int s = 0; s < 2; s++) begin
      do_reset();
      ever = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        step(1'b1, 1'(s), 1'b0);
        ever |= locked;
      end
      check("stuck_state", state_o, 1);
      check("stuck_never_locked", ever, 0);
    end

    // en toggling 0101..: lock after 63 valid bits, 126 cycles.
    do_reset();
    gen_seed();
    n = 0;
    while (!locked && n < 400) begin
      e = 1'(n % 2);
      step(e, e ? gen_bit() : 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    lk_bits = 0;
    check("toggle_lock_cycles", n, 126);
    step(1'b0, ~gen_peek(), 1'b0);
    check("idle_inverted_err", err, 0);
    check("idle_inverted_count", err_count, 0);
    step(1'b1, gen_bit(), 1'b0);
    check("idle_then_clean_err", err, 0);

    // Randomized traffic: random en, clr and error rate alternating low/high.
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 500; i++) begin
        e = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 63) == 0);
        if (e) d = gen_bit() ^ ($urandom_range(0, 99) < ((seg % 2 == 1) ? 15 : 1));
        else   d = 1'($urandom_range(0, 1));
        step(e, d, c);
      end
    end

    // Saturation of the narrow counter with isolated errors.
    do_reset();
    gen_seed();
    wait_lock(200, n);
    check("sat_lock_latency", n, 63);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, gen_bit() ^ 1'b1, 1'b0);
      for (int k = 0; k < 69; k++) step(1'b1, gen_bit(), 1'b0);
    end
    check("sat_count_w4", err_count4, 15);
    check("sat_count_w16", err_count, 20);
    check("sat_locked", locked, 1);

    // Reset while locked.
    do_reset();
    step(1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
